md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
// EX-stage multiply/divide unit: responder to the decoder's MDFunc/MDSign commands.
// Executes mult/multu/div/divu with fixed multi-cycle latency and owns the HI/LO registers.
// Also services mthi/mtlo and produces the MD-hazard stall request for the pipeline.
// PARAMETERS
// MUL_CYCLES  5   busy cycles for mult/multu (>=1)
// DIV_CYCLES  10  busy cycles for div/divu (>=1)
// PORTS
// clk        in   1   clock, all state on rising edge
// reset      in   1   synchronous, active-low reset
// start      in   1   EX holds a valid (unflushed) instruction; qualifies md_func
// md_func    in   3   0 none, 1 mthi, 2 mtlo, 3 mul, 4 div, 5-7 no-op
// md_sign    in   1   1 = signed (mult/div), 0 = unsigned
// rs_val     in   32  operand A / dividend / mthi-mtlo data (forwarded)
// rt_val     in   32  operand B / divisor
// id_md_use  in   1   ID instruction is mfhi/mflo/mthi/mtlo/mult*/div*
// hi         out  32  HI register
// lo         out  32  LO register
// busy       out  1   operation in flight
// md_stall   out  1   stall request to hazard logic
// BEHAVIOUR
// - Reset (reset==0 at edge): hi=0, lo=0, busy=0, state IDLE, cnt=0. Overrides all inputs.
// - States IDLE, BUSY; down-counter cnt. hi/lo/busy are registered outputs.
// - IDLE & start & func==3: latch 64-bit product of rs_val*rt_val (sign per md_sign);
//   cnt=MUL_CYCLES; ->BUSY. func==4: latch quotient/remainder; cnt=DIV_CYCLES; ->BUSY.
// - busy is 1 for exactly N cycles, starting the cycle after the start edge.
// - BUSY: cnt decrements each cycle; at the edge with cnt==1: commit result, ->IDLE, busy=0.
//   Result visible on hi/lo in the first cycle busy==0 (start edge + N+1 cycles later).
// - mul: {hi,lo} = 64-bit product. div: lo=quotient, hi=remainder.
// - Signed div truncates toward zero; remainder takes sign of dividend.
// - 0x80000000 / 0xFFFFFFFF signed: lo=0x80000000, hi=0 (no trap).
// - Divisor 0: full DIV_CYCLES busy, then hi/lo left unchanged.
// - IDLE & start & func==1: hi<=rs_val next edge; func==2: lo<=rs_val. No busy.
// - start with any func while BUSY: ignored; in-flight op and hi/lo unaffected.
// - func 0 or 5-7, or start==0: no state change.
// - md_stall = id_md_use & (busy | (start & state==IDLE & (func==3|func==4))).
//   Combinational; holds the dependent instr in ID until result commits.
// - reset low mid-BUSY: operation aborted, no commit, outputs go to reset values.
// TESTING
// 1. mult 0xFFFFFFFE*3 signed -> busy 1 for 5 cycles, then hi=FFFFFFFF lo=FFFFFFFA.
// 2. multu 0xFFFFFFFE*3 -> hi=00000002 lo=FFFFFFFA after 5 busy cycles.
// 3. div -7/2 signed -> lo=FFFFFFFD hi=FFFFFFFF; divu 7/2 -> lo=3 hi=1; 10 busy cycles.
// 4. mthi 0x11, mtlo 0x22, then div x/0 -> 10 busy cycles, hi=0x11 lo=0x22 after.
// 5. reset=0 at 3rd busy cycle of a div -> next cycle busy=0 hi=lo=0; mthi 5 -> hi=5.
// 6. id_md_use=1 from start edge -> md_stall=1 for 1+MUL_CYCLES cycles.
//    mthi issued during BUSY is ignored.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit owning the HI/LO registers.
// Multiplies and divides are evaluated when accepted, then held for a
// fixed number of busy cycles before being committed to HI/LO, so the
// pipeline sees a constant latency regardless of operand values.
module md_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_func,
    input  logic        md_sign,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        id_md_use,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        md_stall,
    output logic        dbg_state
);

    // Handshake: a command is offered when start=1 and is taken on the
    // rising edge only if the unit is IDLE; anything offered while BUSY is
    // dropped. md_stall is the back-pressure toward ID: it is high whenever
    // an instruction in ID that touches HI/LO must wait, i.e. while an op is
    // in flight or in the cycle a mul/div is being accepted.

    localparam logic [2:0] FUNC_MTHI = 3'd1;
    localparam logic [2:0] FUNC_MTLO = 3'd2;
    localparam logic [2:0] FUNC_MUL  = 3'd3;
    localparam logic [2:0] FUNC_DIV  = 3'd4;

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       res_hi_q, res_hi_d;
    logic [31:0]       res_lo_q, res_lo_d;
    logic              res_ok_q, res_ok_d;

    logic [63:0] op_a_ext;
    logic [63:0] op_b_ext;
    logic [63:0] product;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic        div_zero;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Product: extend to 64 bits per signedness; the low 64 bits of the
    // extended product are the exact signed or unsigned result.
    always_comb begin
        op_a_ext = md_sign ? {{32{rs_val[31]}}, rs_val} : {32'b0, rs_val};
        op_b_ext = md_sign ? {{32{rt_val[31]}}, rt_val} : {32'b0, rt_val};
        product  = op_a_ext * op_b_ext;
    end

    // Quotient/remainder: divide magnitudes, then restore signs so the
    // quotient truncates toward zero and the remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally as 0x80000000 with remainder 0.
    always_comb begin
        a_neg    = md_sign & rs_val[31];
        b_neg    = md_sign & rt_val[31];
        a_mag    = a_neg ? (~rs_val + 32'd1) : rs_val;
        b_mag    = b_neg ? (~rt_val + 32'd1) : rt_val;
        div_zero = (rt_val == 32'd0);
        b_safe   = div_zero ? 32'd1 : b_mag;
        q_mag    = a_mag / b_safe;
        r_mag    = a_mag % b_safe;
        quot     = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem      = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    // Next-state: accept commands in IDLE, count down in BUSY, commit at end.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_ok_d = res_ok_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (md_func)
                        FUNC_MTHI: hi_d = rs_val;
                        FUNC_MTLO: lo_d = rs_val;
                        FUNC_MUL: begin
                            res_hi_d = product[63:32];
                            res_lo_d = product[31:0];
                            res_ok_d = 1'b1;
                            cnt_d    = MUL_CNT;
                            state_d  = S_BUSY;
                        end
                        FUNC_DIV: begin
                            res_hi_d = rem;
                            res_lo_d = quot;
                            // Divide by zero still burns the full latency
                            // but leaves HI/LO untouched.
                            res_ok_d = ~div_zero;
                            cnt_d    = DIV_CNT;
                            state_d  = S_BUSY;
                        end
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (res_ok_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any in-flight operation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            res_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_ok_q <= res_ok_d;
        end
    end

    // Outputs: HI/LO/busy come straight from registers; stall is combinational.
    always_comb begin
        hi        = hi_q;
        lo        = lo_q;
        busy      = (state_q == S_BUSY);
        dbg_state = state_q;
        md_stall  = id_md_use &
                    ((state_q == S_BUSY) |
                     (start & (state_q == S_IDLE) &
                      ((md_func == FUNC_MUL) | (md_func == FUNC_DIV))));
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed bench for md_unit with a cycle-level reference model.
module tb_md_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_func;
    logic        md_sign;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        id_md_use;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        md_stall;
    logic        dbg_state;

    int n_vec  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    // Reference model state
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          m_left = 0;
    logic        m_pend_ok = 1'b0;
    logic [31:0] m_pend_hi = 32'd0;
    logic [31:0] m_pend_lo = 32'd0;

    md_unit #(
        .MUL_CYCLES(MUL_N),
        .DIV_CYCLES(DIV_N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_func   (md_func),
        .md_sign   (md_sign),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .id_md_use (id_md_use),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .md_stall  (md_stall),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else begin
            sa = a;
            sb = b;
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: latency counted in accepted cycles, results from plain arithmetic.
    always @(posedge clk) begin
        logic [63:0] p;
        logic [31:0] q;
        logic [31:0] r;
        if (!reset) begin
            m_hi      = 32'd0;
            m_lo      = 32'd0;
            m_left    = 0;
            m_pend_ok = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pend_ok) begin
                m_hi = m_pend_hi;
                m_lo = m_pend_lo;
            end
        end else if (start) begin
            case (md_func)
                3'd1: m_hi = rs_val;
                3'd2: m_lo = rs_val;
                3'd3: begin
                    p         = ref_mul(md_sign, rs_val, rt_val);
                    m_pend_hi = p[63:32];
                    m_pend_lo = p[31:0];
                    m_pend_ok = 1'b1;
                    m_left    = MUL_N;
                end
                3'd4: begin
                    if (rt_val == 32'd0) begin
                        m_pend_ok = 1'b0;
                    end else begin
                        ref_div(md_sign, rs_val, rt_val, q, r);
                        m_pend_lo = q;
                        m_pend_hi = r;
                        m_pend_ok = 1'b1;
                    end
                    m_left = DIV_N;
                end
                default: ;
            endcase
        end
    end

    // Compare process: every falling edge once reset has been applied.
    always @(negedge clk) begin
        logic exp_busy;
        logic exp_stall;
        if (chk_en) begin
            exp_busy  = (m_left > 0);
            exp_stall = id_md_use & (exp_busy | (start & !exp_busy & (md_func == 3'd3 || md_func == 3'd4)));
            check32("busy", {31'b0, busy}, {31'b0, exp_busy});
            check32("dbg_state", {31'b0, dbg_state}, {31'b0, exp_busy});
            check32("hi", hi, m_hi);
            check32("lo", lo, m_lo);
            check32("md_stall", {31'b0, md_stall}, {31'b0, exp_stall});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic s, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        md_func = f;
        md_sign = s;
        rs_val  = a;
        rt_val  = b;
        @(posedge clk);
        #1;
        start   = 1'b0;
        md_func = 3'd0;
    endtask

    initial begin
        logic [63:0] p;
        logic [31:0] q;
        logic [31:0] r;
        int stall_cnt;

        reset     = 1'b0;
        start     = 1'b0;
        md_func   = 3'd0;
        md_sign   = 1'b0;
        rs_val    = 32'd0;
        rt_val    = 32'd0;
        id_md_use = 1'b0;
        step(2);
        chk_en = 1'b1;
        check32("rst_hi", hi, 32'd0);
        check32("rst_lo", lo, 32'd0);
        check32("rst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b1;
        step(1);

        // Pin the model with hand-computed values
        p = ref_mul(1'b1, 32'hFFFF_FFFE, 32'd3);
        check32("model_mul_s_hi", p[63:32], 32'hFFFF_FFFF);
        check32("model_mul_s_lo", p[31:0], 32'hFFFF_FFFA);
        p = ref_mul(1'b0, 32'hFFFF_FFFE, 32'd3);
        check32("model_mul_u_hi", p[63:32], 32'h0000_0002);
        ref_div(1'b1, 32'hFFFF_FFF9, 32'd2, q, r);
        check32("model_div_q", q, 32'hFFFF_FFFD);
        check32("model_div_r", r, 32'hFFFF_FFFF);

        // Signed multiply
        issue(3'd3, 1'b1, 32'hFFFF_FFFE, 32'd3);
        check32("mul_busy_first", {31'b0, busy}, 32'd1);
        step(MUL_N - 1);
        check32("mul_busy_last", {31'b0, busy}, 32'd1);
        step(1);
        check32("mul_busy_done", {31'b0, busy}, 32'd0);
        check32("mult_hi", hi, 32'hFFFF_FFFF);
        check32("mult_lo", lo, 32'hFFFF_FFFA);

        // Unsigned multiply
        issue(3'd3, 1'b0, 32'hFFFF_FFFE, 32'd3);
        step(MUL_N);
        check32("multu_hi", hi, 32'h0000_0002);
        check32("multu_lo", lo, 32'hFFFF_FFFA);

        // Divides
        issue(3'd4, 1'b1, 32'hFFFF_FFF9, 32'd2);
        step(DIV_N - 1);
        check32("div_busy_last", {31'b0, busy}, 32'd1);
        step(1);
        check32("div_lo", lo, 32'hFFFF_FFFD);
        check32("div_hi", hi, 32'hFFFF_FFFF);
        issue(3'd4, 1'b0, 32'd7, 32'd2);
        step(DIV_N);
        check32("divu_lo", lo, 32'd3);
        check32("divu_hi", hi, 32'd1);
        issue(3'd4, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        step(DIV_N);
        check32("div_ovf_lo", lo, 32'h8000_0000);
        check32("div_ovf_hi", hi, 32'd0);
        issue(3'd4, 1'b1, 32'd7, 32'hFFFF_FFFE);
        step(DIV_N);
        check32("div_negb_lo", lo, 32'hFFFF_FFFD);
        check32("div_negb_hi", hi, 32'd1);

        // mthi/mtlo then divide by zero
        issue(3'd1, 1'b0, 32'h11, 32'd0);
        check32("mthi", hi, 32'h11);
        issue(3'd2, 1'b0, 32'h22, 32'd0);
        check32("mtlo", lo, 32'h22);
        issue(3'd4, 1'b1, 32'd100, 32'd0);
        step(DIV_N - 1);
        check32("div0_busy_last", {31'b0, busy}, 32'd1);
        step(1);
        check32("div0_busy_done", {31'b0, busy}, 32'd0);
        check32("div0_hi", hi, 32'h11);
        check32("div0_lo", lo, 32'h22);

        // No-op functions and unqualified commands
        issue(3'd5, 1'b0, 32'hAAAA, 32'd1);
        issue(3'd7, 1'b1, 32'hBBBB, 32'd1);
        issue(3'd0, 1'b0, 32'hCCCC, 32'd1);
        md_func = 3'd3;
        rs_val  = 32'd9;
        step(1);
        md_func = 3'd0;
        check32("noop_busy", {31'b0, busy}, 32'd0);
        check32("noop_hi", hi, 32'h11);

        // Reset during the third busy cycle of a divide
        issue(3'd4, 1'b0, 32'd1000, 32'd7);
        step(2);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        check32("abort_busy", {31'b0, busy}, 32'd0);
        check32("abort_hi", hi, 32'd0);
        check32("abort_lo", lo, 32'd0);
        issue(3'd1, 1'b0, 32'd5, 32'd0);
        check32("abort_mthi", hi, 32'd5);
        step(DIV_N + 2);
        check32("abort_no_commit", lo, 32'd0);

        // Stall window and commands dropped while busy
        id_md_use = 1'b1;
        start     = 1'b1;
        md_func   = 3'd3;
        md_sign   = 1'b0;
        rs_val    = 32'h0001_0000;
        rt_val    = 32'h0001_0000;
        stall_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (md_stall) stall_cnt++;
            @(posedge clk);
            #1;
            start   = 1'b0;
            md_func = 3'd0;
            if (i == 2) begin
                start   = 1'b1;
                md_func = 3'd1;
                rs_val  = 32'h0000_DEAD;
            end
            if (i == 3) begin
                start   = 1'b1;
                md_func = 3'd4;
                rs_val  = 32'd9;
                rt_val  = 32'd2;
            end
        end
        id_md_use = 1'b0;
        check32("stall_cycles", 32'(stall_cnt), 32'(1 + MUL_N));
        check32("busy_drop_hi", hi, 32'd1);
        check32("busy_drop_lo", lo, 32'd0);

        step(3);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
